// File: rtl/ppu_pkg.sv
// Shared PPU definitions: scheduler state encoding, default raster geometry
// and the saturating line_start counter helper.
package ppu_pkg;

  localparam int PPU_H_PIXELS   = 400;
  localparam int PPU_V_LINES    = 300;
  localparam int PPU_PIPE_DEPTH = 3;
  localparam int PPU_PRELOAD_Y  = 665;

  typedef enum logic [1:0] {
    FRAME_WAIT = 2'd0,
    RENDER     = 2'd1,
    DRAIN      = 2'd2,
    LINE_WAIT  = 2'd3
  } sched_state_t;

  // 2-bit counter that sticks at 3
  function automatic logic [1:0] sat_inc2(input logic [1:0] c, input logic inc);
    return (inc && c != 2'd3) ? c + 2'd1 : c;
  endfunction

endpackage

// File: rtl/line_render_sched_if.sv
// Scan-side inputs and renderer/line-RAM outputs of the line render scheduler.
interface line_render_sched_if;
  logic        line_start;
  logic [10:0] counter_x;
  logic [9:0]  counter_y;
  logic [8:0]  scroll_x_in;
  logic [8:0]  scroll_y_in;
  logic        overrun_clr;
  logic [8:0]  work_x;
  logic [8:0]  work_y;
  logic [8:0]  work_x_scr;
  logic [8:0]  work_y_scr;
  logic        issue_en;
  logic        wr_en;
  logic [9:0]  wr_addr;
  logic        frame_done;
  logic        overrun;

  modport master (
    output line_start, counter_x, counter_y, scroll_x_in, scroll_y_in, overrun_clr,
    input  work_x, work_y, work_x_scr, work_y_scr, issue_en, wr_en, wr_addr,
           frame_done, overrun
  );

  modport slave (
    input  line_start, counter_x, counter_y, scroll_x_in, scroll_y_in, overrun_clr,
    output work_x, work_y, work_x_scr, work_y_scr, issue_en, wr_en, wr_addr,
           frame_done, overrun
  );
endinterface

// File: rtl/pipe_delay.sv
// Fixed-latency shift register; async reset clears every stage so the
// delayed valid drops the moment reset asserts.
module pipe_delay #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
) (
  input  logic             vga_clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [DEPTH-1:0][WIDTH-1:0] sr;

  always_ff @(posedge vga_clk or negedge rst_n) begin
    if (!rst_n) begin
      sr <= '0;
    end else begin
      sr[0] <= d;
      for (int i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
    end
  end

  assign q = sr[DEPTH-1];

endmodule

// File: rtl/line_render_sched.sv
// Paces background rendering against VGA scan: one render line per two
// scanlines into a double-banked line RAM, line 0 pre-rendered before frame start.
module line_render_sched
  import ppu_pkg::*;
#(
  parameter int H_PIXELS   = PPU_H_PIXELS,
  parameter int V_LINES    = PPU_V_LINES,
  parameter int PIPE_DEPTH = PPU_PIPE_DEPTH,
  parameter int PRELOAD_Y  = PPU_PRELOAD_Y
) (
  input logic                vga_clk,
  input logic                rst_n,
  line_render_sched_if.slave bus
);

  localparam int DCW = (PIPE_DEPTH > 1) ? $clog2(PIPE_DEPTH) : 1;

  sched_state_t   state, state_nxt;
  logic [8:0]     work_x, work_y, scroll_x_sh, scroll_y_sh;
  logic [1:0]     line_cnt, cnt_inc, cnt_nxt;
  logic [DCW-1:0] drain_cnt;
  logic           overrun_q, frame_done_q;
  logic           preload, line_last, drain_last, last_row;
  logic           advance, frame_end, ovr_set, issue_en;
  logic [10:0]    wr_q;

  assign preload    = (bus.counter_y == 10'(PRELOAD_Y)) && (bus.counter_x == '0);
  assign line_last  = (work_x == 9'(H_PIXELS - 1));
  assign drain_last = (drain_cnt == DCW'(PIPE_DEPTH - 1));
  assign last_row   = (work_y >= 9'(V_LINES - 1));
  assign cnt_inc    = sat_inc2(line_cnt, bus.line_start);
  assign issue_en   = (state == RENDER);
  // second scanline arrived before this line finished: scan is about to show stale data
  assign ovr_set    = (state == RENDER || state == DRAIN) && bus.line_start && cnt_inc[1];

  always_comb begin
    state_nxt = state;
    cnt_nxt   = line_cnt;
    advance   = 1'b0;
    frame_end = 1'b0;
    case (state)
      FRAME_WAIT: begin
        cnt_nxt = '0;
        if (preload) state_nxt = RENDER;
      end
      RENDER: begin
        cnt_nxt = cnt_inc;
        if (line_last) state_nxt = DRAIN;
      end
      DRAIN: begin
        cnt_nxt = cnt_inc;
        if (drain_last) begin
          if (cnt_inc[1]) advance = 1'b1;
          else            state_nxt = LINE_WAIT;
        end
      end
      LINE_WAIT: begin
        cnt_nxt = cnt_inc;
        advance = cnt_inc[1];
      end
      default: state_nxt = FRAME_WAIT;
    endcase
    if (advance) begin
      cnt_nxt = '0;
      if (last_row) begin
        state_nxt = FRAME_WAIT;
        frame_end = 1'b1;
      end else begin
        state_nxt = RENDER;
      end
    end
  end

  always_ff @(posedge vga_clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= FRAME_WAIT;
      line_cnt     <= '0;
      drain_cnt    <= '0;
      work_x       <= '0;
      work_y       <= '0;
      scroll_x_sh  <= '0;
      scroll_y_sh  <= '0;
      frame_done_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state        <= state_nxt;
      line_cnt     <= cnt_nxt;
      frame_done_q <= frame_end;
      drain_cnt    <= (state == DRAIN && !drain_last) ? drain_cnt + 1'b1 : '0;

      // scroll is frozen for the whole frame at the preload point
      if (state == FRAME_WAIT && preload) begin
        work_x      <= '0;
        work_y      <= '0;
        scroll_x_sh <= bus.scroll_x_in;
        scroll_y_sh <= bus.scroll_y_in;
      end else if (state == RENDER) begin
        work_x <= line_last ? '0 : work_x + 1'b1;
      end

      if (advance && !last_row) work_y <= work_y + 1'b1;

      if (ovr_set)              overrun_q <= 1'b1;
      else if (bus.overrun_clr) overrun_q <= 1'b0;
    end
  end

  // delayed coordinate lines up with renderer output, so no address math on the write side
  pipe_delay #(.WIDTH(11), .DEPTH(PIPE_DEPTH)) u_wr_dly (
    .vga_clk (vga_clk),
    .rst_n   (rst_n),
    .d       ({issue_en, work_y[0], work_x}),
    .q       (wr_q)
  );

  assign bus.wr_en      = wr_q[10];
  assign bus.wr_addr    = wr_q[9:0];
  assign bus.issue_en   = issue_en;
  assign bus.work_x     = work_x;
  assign bus.work_y     = work_y;
  assign bus.work_x_scr = work_x + scroll_x_sh;
  assign bus.work_y_scr = work_y + scroll_y_sh;
  assign bus.frame_done = frame_done_q;
  assign bus.overrun    = overrun_q;

endmodule

// File: tb/tb_line_render_sched.sv
// Line render scheduler bench: cycle-timeline reference model plus a table of
// per-line line_start/overrun_clr scenarios and a randomized phase.
module tb_line_render_sched;

  localparam int H  = 400;
  localparam int V  = 3;
  localparam int P  = 3;
  localparam int PY = 665;

  logic vga_clk = 1'b0;
  logic rst_n   = 1'b0;
  always #5 vga_clk = ~vga_clk;

  line_render_sched_if bus();

  line_render_sched #(.H_PIXELS(H), .V_LINES(V), .PIPE_DEPTH(P), .PRELOAD_Y(PY)) dut (
    .vga_clk (vga_clk),
    .rst_n   (rst_n),
    .bus     (bus)
  );

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  // reference model: a line is a cycle window starting at m_start
  bit m_busy, m_ovr;
  int m_start, m_y, m_sx, m_sy, m_pulses, m_fd;

  typedef struct {
    int p1, p2, clr, ovr, nxt, last;
  } row_t;
  row_t rows[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      if (fails <= 20)
        $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_ovr = 0; m_start = 0; m_y = 0;
    m_sx = 0; m_sy = 0; m_pulses = 0; m_fd = -10;
  endtask

  task automatic check_outputs();
    int k;
    bit iss, wr;
    k   = cyc - m_start;
    iss = m_busy && k >= 0 && k < H;
    wr  = m_busy && k >= P && k < H + P;
    chk("issue_en", bus.issue_en, iss);
    chk("wr_en", bus.wr_en, wr);
    if (wr) chk("wr_addr", bus.wr_addr, ((m_y % 2) << 9) | (k - P));
    chk("work_x", bus.work_x, iss ? k : 0);
    chk("work_y", bus.work_y, m_y);
    chk("work_x_scr", bus.work_x_scr, ((iss ? k : 0) + m_sx) % 512);
    chk("work_y_scr", bus.work_y_scr, (m_y + m_sy) % 512);
    chk("frame_done", bus.frame_done, cyc == m_fd);
    chk("overrun", bus.overrun, m_ovr);
  endtask

  // model consumes this cycle's inputs, clock advances, outputs compared
  task automatic tick();
    bit set;
    set = 0;
    if (!m_busy) begin
      if (bus.counter_y == 10'(PY) && bus.counter_x == 11'd0) begin
        m_busy = 1; m_y = 0; m_start = cyc + 1; m_pulses = 0;
        m_sx = int'(bus.scroll_x_in); m_sy = int'(bus.scroll_y_in);
      end
    end else begin
      if (bus.line_start) begin
        m_pulses = (m_pulses < 3) ? m_pulses + 1 : 3;
        set = (m_pulses >= 2) && (cyc <= m_start + H + P - 1);
      end
      if (cyc >= m_start + H + P - 1 && m_pulses >= 2) begin
        if (m_y < V - 1) begin
          m_y++; m_start = cyc + 1; m_pulses = 0;
        end else begin
          m_busy = 0; m_fd = cyc + 1;
        end
      end
    end
    if (set) m_ovr = 1;
    else if (bus.overrun_clr) m_ovr = 0;
    @(posedge vga_clk); #1;
    cyc++;
    check_outputs();
    bus.scroll_x_in = 9'($urandom_range(0, 511));
    bus.scroll_y_in = 9'($urandom_range(0, 511));
    bus.counter_y   = 10'($urandom_range(0, PY - 1));
    bus.counter_x   = 11'($urandom_range(0, 1599));
  endtask

  task automatic do_preload(input logic [8:0] sx, input logic [8:0] sy);
    bus.counter_y = 10'(PY); bus.counter_x = '0;
    bus.scroll_x_in = sx; bus.scroll_y_in = sy;
    bus.line_start = 0; bus.overrun_clr = 0;
    tick();
  endtask

  task automatic fw_idle();
    for (int i = 0; i < 40; i++) begin
      bus.line_start = (i % 8 == 0);
      if (i == 20) begin bus.counter_y = 10'(PY); bus.counter_x = 11'd5; end
      tick();
      chk("fw_no_issue", bus.issue_en, 0);
    end
    bus.line_start = 0;
  endtask

  initial begin
    //         p1   p2   clr  ovr nxt  last
    rows[0] = '{410, 420, -1,  0, 421, 0};
    rows[1] = '{100, 200, -1,  1, 403, 0};
    rows[2] = '{402, 403,  0,  0, 404, 1};
    rows[3] = '{401, 402, 402, 1, 403, 0};
    rows[4] = '{5,   420, 10,  0, 421, 0};
    rows[5] = '{0,   1,   -1,  1, 403, 1};

    bus.line_start = 0; bus.overrun_clr = 0;
    bus.counter_x = '0; bus.counter_y = '0;
    bus.scroll_x_in = '0; bus.scroll_y_in = '0;
    model_reset();
    @(posedge vga_clk); #1; cyc++;
    @(posedge vga_clk); #1; cyc++;
    check_outputs();
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) tick();

    for (int ri = 0; ri < 6; ri++) begin
      if (ri == 0) do_preload(9'd5, 9'd0);
      if (ri == 3) begin fw_idle(); do_preload(9'd200, 9'd510); end
      if (ri < 3) chk("scr_x_at_x0", bus.work_x_scr, 5);
      else        chk("scr_y_line", bus.work_y_scr, (510 + ri - 3) % 512);
      for (int off = 0; off < rows[ri].nxt; off++) begin
        if (ri == 0 && off == 2)   chk("wr_en_before_latency", bus.wr_en, 0);
        if (ri == 0 && off == 3)   chk("first_wr_addr", bus.wr_addr, 10'h000);
        if (ri == 0 && off == 402) chk("last_wr_addr", bus.wr_addr, 10'h18F);
        if (ri == 1 && off == 3)   chk("bank1_first_wr_addr", bus.wr_addr, 10'h200);
        if (ri == 1 && off == 402) chk("bank1_last_wr_addr", bus.wr_addr, 10'h38F);
        if (ri == 3 && off == 399) chk("scr_x_wrap", bus.work_x_scr, 87);
        bus.line_start  = (off == rows[ri].p1) || (off == rows[ri].p2);
        bus.overrun_clr = (off == rows[ri].clr);
        tick();
      end
      bus.line_start = 0; bus.overrun_clr = 0;
      chk("row_overrun", bus.overrun, rows[ri].ovr);
      if (rows[ri].last != 0) begin
        chk("row_frame_done", bus.frame_done, 1);
      end else begin
        chk("row_next_issue", bus.issue_en, 1);
        chk("row_next_work_y", bus.work_y, (ri % 3) + 1);
      end
    end
    fw_idle();

    // randomized frames: sparse line_start and overrun_clr against the model
    for (int f = 0; f < 3; f++) begin
      int n;
      do_preload(9'($urandom_range(0, 511)), 9'($urandom_range(0, 511)));
      n = 0;
      while (m_busy && n < 20000) begin
        bus.line_start  = ($urandom_range(0, 249) == 0);
        bus.overrun_clr = ($urandom_range(0, 399) == 0);
        tick();
        n++;
      end
      bus.line_start = 0; bus.overrun_clr = 0;
      chk("rand_frame_timeout", m_busy, 0);
      for (int i = 0; i < 10; i++) tick();
    end

    // reset in the middle of a rendered line
    do_preload(9'd7, 9'd3);
    for (int i = 0; i < 200; i++) tick();
    chk("pre_reset_work_x", bus.work_x, 200);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_issue_en", bus.issue_en, 0);
    chk("rst_wr_en", bus.wr_en, 0);
    chk("rst_work_x", bus.work_x, 0);
    chk("rst_work_y_scr", bus.work_y_scr, 0);
    model_reset();
    @(posedge vga_clk); #1; cyc++;
    check_outputs();
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    do_preload(9'd1, 9'd2);
    for (int i = 0; i < 10; i++) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #5000000;
    fails++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1);
  end

endmodule
